sdram_sched: RTL
================

Name: sdram_sched

Overview:
- SDRAM-clock-side scheduler for the 8-channel tx FIFO bank.
- Decides which FIFO channel the SDR FSM serves next, holds that selection for the whole burst, and interleaves refresh between bursts.
- Priority classes: high = channels 4-7, low = channels 0-3.
- Round-robin within each class, plus a starvation guard that forces a low-class grant after too many consecutive high-class grants.

Parameters:
- PORT_MASK, 8'hFF, enabled channels; a masked channel is never granted.
- STARVE_W, 4, width of the starvation counter.
- STARVE_LIMIT, 8, consecutive high-class grants tolerated while low class is pending; must be < 2^STARVE_W.

Ports:
- sdram_clk  in  1  sole clock.
- wb_rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  8  per-channel empty flags from the tx FIFO B side.
- ctrl_idle  in  1  SDR FSM is ready to accept a new burst or refresh.
- done  in  1  one-cycle pulse: current burst finished.
- ref_req  in  1  level; refresh counter requests a refresh.
- ref_done  in  1  one-cycle pulse: refresh command sequence finished.
- adr_init  out  1  one-cycle pulse: start burst on fifo_sel.
- fifo_sel  out  3  granted channel; stable from adr_init until done.
- busy  out  1  burst or refresh in progress.
- ref_ack  out  1  one-cycle pulse: refresh granted.

Behaviour:
- Reset values: adr_init=0, fifo_sel=0, busy=0, ref_ack=0, state=IDLE, both RR pointers=0, starve_cnt=0.
- Outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, START, BURST, REF.
- IDLE, when ctrl_idle=1, evaluates in priority order:
  - ref_req=1 -> REF; ref_ack=1 in the next cycle only.
  - Else if any enabled channel is non-empty -> pick winner, register fifo_sel -> START.
  - Else stay in IDLE.
- IDLE with ctrl_idle=0: no decision is made.
- START: adr_init=1 for exactly one cycle, busy=1 -> BURST.
- BURST: busy=1 and fifo_sel held. done=1 -> IDLE. ref_req is deferred until the burst ends.
- REF: busy=1. ref_done=1 -> IDLE.
- Ignored inputs: done outside BURST; ref_done outside REF; done arriving in START (no early exit).
- Latency: IDLE decision at cycle N; adr_init at N+1; earliest next decision at the cycle after done. Minimum one IDLE cycle between grants.
- Winner selection, with lowpend = any enabled non-empty channel in 0-3:
  - forced = lowpend & (starve_cnt == STARVE_LIMIT). If forced, grant the low-class RR pick.
  - Else, if any high-class channel is pending, grant the high-class RR pick.
  - Else grant the low-class RR pick.
- RR within a class:
  - Search starts at ptr and wraps modulo 4 over the class members.
  - On grant, the pointer of that class is set to the granted index + 1 (mod 4); the other class pointer is unchanged.
- starve_cnt:
  - On a high-class grant with lowpend=1: increment, saturating at 2^STARVE_W-1.
  - On a low-class grant, or on any grant with lowpend=0: clear.
- fifo_empty changing during START/BURST has no effect on fifo_sel.
- Reset asserted mid-burst or mid-refresh: immediate return to reset values; no pulse is emitted on release.
- ref_req and a non-empty FIFO in the same IDLE cycle: refresh wins; the burst is arbitrated after ref_done.

Decomposition:
- Shared package sdram_sched_pkg:
  - state encoding (IDLE, START, BURST, REF);
  - HI_BASE=4 and LO_BASE=0 class constants;
  - channel-count constant 8.
- One sub-module, rr_pick4: 4-bit request vector + 2-bit pointer in, found flag + 2-bit index out, purely combinational. Instantiated twice, once per class.

Test Plan:
- Reset, then fifo_empty=8'hFE, ctrl_idle=1 -> adr_init pulse one cycle later, fifo_sel=0, busy=1 until done, then IDLE.
- Channels 0 and 5 non-empty -> fifo_sel=5 first; after done, channel 5 emptied -> fifo_sel=0.
- Channels 4-7 continuously non-empty -> grants 4,5,6,7,4.
- Channels 4-7 and 1 continuously non-empty, STARVE_LIMIT=8 -> 8 high grants, 9th grant fifo_sel=1, starve_cnt back to 0.
- ref_req raised mid-BURST -> no ref_ack until done. ref_req and a pending channel in the same IDLE cycle -> ref_ack first, adr_init only after ref_done.
- wb_rst_n low during BURST -> all outputs 0 immediately. PORT_MASK=8'h0F with channel 6 non-empty -> channel 6 never granted.
- Spurious done in IDLE and ref_done in BURST -> no state change.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM-side tx FIFO scheduler.
// Channels 4-7 form the high class, channels 0-3 the low class.
package sdram_sched_pkg;

  localparam int NCH     = 8;
  localparam int HI_BASE = 4;
  localparam int LO_BASE = 0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BURST,
    REF
  } state_t;

endpackage

// File: rtl/sdram_sched_rr_pick4.sv
// Four-way round-robin picker: first request at or after ptr, wrapping.
// Purely combinational; one instance per priority class.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk offsets high to low so the nearest request overwrites last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_sched.sv
// Burst/refresh scheduler: picks the next tx FIFO channel for the
// SDR FSM, holds it for the burst and slots refreshes between bursts.
module sdram_sched
  import sdram_sched_pkg::*;
#(
  parameter logic [7:0] PORT_MASK    = 8'hFF,
  parameter int         STARVE_W     = 4,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic       sdram_clk,
  input  logic       wb_rst_n,
  input  logic [7:0] fifo_empty,
  input  logic       ctrl_idle,
  input  logic       done,
  input  logic       ref_req,
  input  logic       ref_done,
  output logic       adr_init,
  output logic [2:0] fifo_sel,
  output logic       busy,
  output logic       ref_ack
);

  state_t state;
  state_t state_nx;

  logic [NCH-1:0]      req;
  logic [3:0]          lo_req;
  logic [3:0]          hi_req;
  logic [1:0]          lo_ptr;
  logic [1:0]          hi_ptr;
  logic [1:0]          lo_idx;
  logic [1:0]          hi_idx;
  logic                lo_found;
  logic                hi_found;
  logic [STARVE_W-1:0] starve_cnt;
  logic                forced;
  logic                pick_lo;
  logic                grant;
  logic                take_ref;
  logic [2:0]          win_sel;

  assign req    = ~fifo_empty & PORT_MASK;
  assign lo_req = req[LO_BASE +: 4];
  assign hi_req = req[HI_BASE +: 4];

  rr_pick4 u_lo (
    .req   (lo_req),
    .ptr   (lo_ptr),
    .found (lo_found),
    .idx   (lo_idx)
  );

  rr_pick4 u_hi (
    .req   (hi_req),
    .ptr   (hi_ptr),
    .found (hi_found),
    .idx   (hi_idx)
  );

  assign forced  = lo_found &&
                   (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign pick_lo = forced || !hi_found;
  assign win_sel = pick_lo ? 3'(LO_BASE) + {1'b0, lo_idx}
                           : 3'(HI_BASE) + {1'b0, hi_idx};

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    take_ref = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl_idle) begin
          if (ref_req) begin
            take_ref = 1'b1;
            state_nx = REF;
          end else if (lo_found || hi_found) begin
            grant    = 1'b1;
            state_nx = START;
          end
        end
      end
      START: state_nx = BURST;
      BURST: if (done) state_nx = IDLE;
      REF:   if (ref_done) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      adr_init <= 1'b0;
      fifo_sel <= 3'd0;
      busy     <= 1'b0;
      ref_ack  <= 1'b0;
    end else begin
      state    <= state_nx;
      adr_init <= grant;
      ref_ack  <= take_ref;
      busy     <= (state_nx != IDLE);
      if (grant) fifo_sel <= win_sel;
    end
  end

  // Pointers advance past the winner; starvation counts high grants
  // only while the low class is actually waiting.
  always_ff @(posedge sdram_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      lo_ptr     <= 2'd0;
      hi_ptr     <= 2'd0;
      starve_cnt <= '0;
    end else if (grant) begin
      if (pick_lo) begin
        lo_ptr     <= lo_idx + 2'd1;
        starve_cnt <= '0;
      end else begin
        hi_ptr <= hi_idx + 2'd1;
        if (!lo_found) begin
          starve_cnt <= '0;
        end else if (starve_cnt != '1) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule
